regfile_wb_arbiter: RTL and testbench

Write-port controller for the 32x32 register bank. Shares the bank's single write port (WE3/A3/WD3) between two writeback requesters: ALU writeback on port 0 and load unit on port 1. Both ports use valid/ready handshakes and round-robin arbitration. Also runs a clear sequence that zeroes registers 1..NREG-1 through the normal write port, one register per cycle, with no dependence on the bank's own reset.

---
 rtl/regfile_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the 32x32 register bank: round-robin between ALU (port 0) and load (port 1),
// plus a zeroing sweep of registers 1..NREG-1. Define WB_BYPASS_EN to add the read-bypass ports.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr0_valid,
  output logic              wr0_ready,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_valid,
  output logic              wr1_ready,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] byp_ra1,
  input  logic [ADDR_W-1:0] byp_ra2,
  input  logic [DATA_W-1:0] byp_rd1_in,
  input  logic [DATA_W-1:0] byp_rd2_in,
  output logic [DATA_W-1:0] byp_rd1,
  output logic [DATA_W-1:0] byp_rd2
`endif
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  state_t            state_q;
  logic              prio_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic              clr_busy_q;
  logic              clr_done_q;

  logic accept_ok;
  logic gnt0;
  logic gnt1;

  // A clear request in IDLE blocks both ports in that same cycle.
  assign accept_ok = (state_q == IDLE) && !clr_start;
  assign gnt0      = accept_ok && wr0_valid && (!wr1_valid || !prio_q);
  assign gnt1      = accept_ok && wr1_valid && (!wr0_valid ||  prio_q);

  assign wr0_ready = gnt0;
  assign wr1_ready = gnt1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      cnt_q      <= ONE;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      rf_we_q    <= 1'b0;
      clr_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clr_start) begin
            state_q    <= CLEAR;
            clr_busy_q <= 1'b1;
          end else if (gnt0) begin
            rf_we_q    <= (wr0_addr != '0);
            rf_waddr_q <= wr0_addr;
            rf_wdata_q <= wr0_data;
            prio_q     <= 1'b1;
          end else if (gnt1) begin
            rf_we_q    <= (wr1_addr != '0);
            rf_waddr_q <= wr1_addr;
            rf_wdata_q <= wr1_data;
            prio_q     <= 1'b0;
          end
        end
        CLEAR: begin
          rf_we_q    <= 1'b1;
          rf_waddr_q <= cnt_q;
          rf_wdata_q <= '0;
          if (cnt_q == LAST) begin
            cnt_q      <= ONE;
            state_q    <= IDLE;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

`ifdef WB_BYPASS_EN
  // Forward the write that the bank captures at the end of this cycle.
  assign byp_rd1 = (rf_we_q && (rf_waddr_q == byp_ra1) && (byp_ra1 != '0)) ? rf_wdata_q : byp_rd1_in;
  assign byp_rd2 = (rf_we_q && (rf_waddr_q == byp_ra2) && (byp_ra2 != '0)) ? rf_wdata_q : byp_rd2_in;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: handshake, round-robin, address 0, clear sweep, reset abort.
module tb_regfile_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr0_valid = 1'b0, wr1_valid = 1'b0, clr_start = 1'b0;
  logic [ADDR_W-1:0] wr0_addr = '0, wr1_addr = '0;
  logic [DATA_W-1:0] wr0_data = '0, wr1_data = '0;
  logic              wr0_ready, wr1_ready, clr_busy, clr_done, rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
`ifdef WB_BYPASS_EN
  logic [ADDR_W-1:0] byp_ra1 = '0, byp_ra2 = '0;
  logic [DATA_W-1:0] byp_rd1_in = '0, byp_rd2_in = '0;
  logic [DATA_W-1:0] byp_rd1, byp_rd2;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef WB_BYPASS_EN
    ,
    .byp_ra1(byp_ra1), .byp_ra2(byp_ra2), .byp_rd1_in(byp_rd1_in), .byp_rd2_in(byp_rd2_in),
    .byp_rd1(byp_rd1), .byp_rd2(byp_rd2)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_p0;
    int                done_cnt;
    int                guard;

    #2;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_busy", clr_busy, 0);
    chk("rst_done", clr_done, 0);
    @(negedge clk);
    rst = 1'b1;
    cyc();

    // Contention: grants alternate 0,1,0,1 starting from port 0.
    wr0_valid = 1; wr0_addr = 3; wr0_data = 32'h11;
    wr1_valid = 1; wr1_addr = 4; wr1_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      exp_p0   = (i % 2 == 0);
      exp_addr = exp_p0 ? 5'd3 : 5'd4;
      #1;
      chk($sformatf("rr_rdy0_%0d", i), wr0_ready, exp_p0);
      chk($sformatf("rr_rdy1_%0d", i), wr1_ready, !exp_p0);
      cyc();
      chk($sformatf("rr_addr_%0d", i), rf_waddr, exp_addr);
      chk($sformatf("rr_data_%0d", i), rf_wdata, exp_p0 ? 32'h11 : 32'h22);
      chk($sformatf("rr_we_%0d", i), rf_we, 1);
    end
    wr0_valid = 0; wr1_valid = 0;

    // Single port 0 write.
    wr0_valid = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
    #1;
    chk("p0_ready", wr0_ready, 1);
    cyc();
    wr0_valid = 0;
    chk("p0_we", rf_we, 1);
    chk("p0_waddr", rf_waddr, 5);
    chk("p0_wdata", rf_wdata, 32'hDEADBEEF);
    cyc();
    chk("p0_we_off", rf_we, 0);
    chk("p0_waddr_hold", rf_waddr, 5);

    // Address 0 on port 1: accepted, no write strobe.
    wr1_valid = 1; wr1_addr = 0; wr1_data = 32'hFFFFFFFF;
    #1;
    chk("a0_ready", wr1_ready, 1);
    cyc();
    wr1_valid = 0;
    chk("a0_we", rf_we, 0);
    chk("a0_waddr", rf_waddr, 0);
    chk("a0_wdata", rf_wdata, 32'hFFFFFFFF);

    // Same address on both ports: prio=0 so port 0 first, port 1 last.
    wr0_valid = 1; wr0_addr = 9; wr0_data = 32'hA;
    wr1_valid = 1; wr1_addr = 9; wr1_data = 32'hB;
    #1;
    chk("same_rdy0", wr0_ready, 1);
    cyc();
    wr0_valid = 0;
    chk("same_first", rf_wdata, 32'hA);
    #1;
    chk("same_rdy1", wr1_ready, 1);
    cyc();
    wr1_valid = 0;
    chk("same_last", rf_wdata, 32'hB);
    chk("same_addr", rf_waddr, 9);

    // Clear sweep with port 0 waiting throughout.
    wr0_valid = 1; wr0_addr = 6; wr0_data = 32'h66;
    clr_start = 1;
    #1;
    chk("clr_start_rdy0", wr0_ready, 0);
    cyc();
    clr_start = 0;
    #1;
    chk("clr_entry_busy", clr_busy, 1);
    chk("clr_entry_rdy0", wr0_ready, 0);
    chk("clr_entry_we", rf_we, 0);
    done_cnt = 0;
    for (int i = 1; i <= NREG - 1; i++) begin
      if (i == 5) clr_start = 1;
      cyc();
      clr_start = 0;
      #1;
      if (clr_done) done_cnt++;
      chk($sformatf("clr_we_%0d", i), rf_we, 1);
      chk($sformatf("clr_addr_%0d", i), rf_waddr, i);
      chk($sformatf("clr_data_%0d", i), rf_wdata, 0);
      chk($sformatf("clr_busy_%0d", i), clr_busy, (i != NREG - 1));
      chk($sformatf("clr_rdy0_%0d", i), wr0_ready, (i == NREG - 1));
    end
    cyc();
    if (clr_done) done_cnt++;
    chk("clr_done_pulses", done_cnt, 1);
    chk("post_clr_we", rf_we, 1);
    chk("post_clr_addr", rf_waddr, 6);
    chk("post_clr_data", rf_wdata, 32'h66);
    wr0_valid = 0;
    cyc();
    chk("post_clr_busy", clr_busy, 0);

    // Reset mid-clear once register 10 is being written.
    clr_start = 1;
    cyc();
    clr_start = 0;
    guard = 0;
    while (rf_waddr != 10 && guard < 40) begin
      cyc();
      guard++;
    end
    chk("mid_reached10", rf_waddr, 10);
    rst = 0;
    #1;
    chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_busy", clr_busy, 0);
    chk("mid_rst_waddr", rf_waddr, 0);
    cyc();
    @(negedge clk);
    rst = 1;
    guard = 0;
    for (int i = 0; i < NREG + 4; i++) begin
      cyc();
      if (rf_we || clr_busy) guard++;
    end
    chk("no_resume", guard, 0);
    wr0_valid = 1; wr0_addr = 1; wr0_data = 32'h1;
    wr1_valid = 1; wr1_addr = 2; wr1_data = 32'h2;
    #1;
    chk("rst_prio_rdy0", wr0_ready, 1);
    chk("rst_prio_rdy1", wr1_ready, 0);
    cyc();
    wr0_valid = 0; wr1_valid = 0;

`ifdef WB_BYPASS_EN
    wr0_valid = 1; wr0_addr = 7; wr0_data = 32'h1234;
    cyc();
    wr0_valid = 0;
    byp_ra1 = 7; byp_rd1_in = 0;
    byp_ra2 = 0; byp_rd2_in = 32'hABCD;
    #1;
    chk("byp_rd1", byp_rd1, 32'h1234);
    chk("byp_rd2", byp_rd2, 32'hABCD);
    cyc();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
